// File: rtl/reaction_pkg.sv
`default_nettype none
// ============================================================================
// reaction_pkg : shared state encoding, result width and helpers
// Rev 1.0
// ============================================================================
package reaction_pkg;

    localparam int RES_W = 14;
    localparam logic [RES_W-1:0] EARLY_CODE = 14'd9999;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQ       = 3'd1,
        WAIT_RAND = 3'd2,
        DELAY     = 3'd3,
        STIM      = 3'd4,
        RESULT    = 3'd5,
        ERR       = 3'd6
    } rt_state_t;

    // Millisecond counters stick at all-ones instead of wrapping.
    function automatic logic [RES_W-1:0] sat_inc(input logic [RES_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ms_tick_gen.sv
`default_nettype none
// ============================================================================
// ms_tick_gen : one-cycle pulse every CLK_FREQ/1000 cycles after clear
// Rev 1.0
// ============================================================================
module ms_tick_gen #(
    parameter int CLK_FREQ = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic o_tick
);
    localparam int TICK_CYC = (CLK_FREQ / 1000 < 2) ? 2 : CLK_FREQ / 1000;
    localparam int CNT_W    = $clog2(TICK_CYC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYC - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign o_tick = !clear && (cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/reaction_timer_ctrl.sv
`default_nettype none
// ============================================================================
// reaction_timer_ctrl : requests a random delay, lights the stimulus LED and
// measures reaction time in ms. Rev 1.0
// ============================================================================
module reaction_timer_ctrl
    import reaction_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int LOWER_MS   = 2000,
    parameter int UPPER_MS   = 15000,
    parameter int TIMEOUT_MS = 1000,
    parameter int WAIT_CYC   = 1000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_clear,
    input  logic [31:0]      i_seed,
    output logic             o_gen,
    output logic [31:0]      o_seed,
    output logic [31:0]      o_lower,
    output logic [31:0]      o_upper,
    input  logic             i_rg_ready,
    input  logic             i_rg_done,
    input  logic             i_rg_invalid,
    input  logic [31:0]      i_rg_val,
    output logic             o_stim_led,
    output logic [RES_W-1:0] o_time_ms,
    output logic             o_busy,
    output logic             o_early,
    output logic             o_timeout,
    output logic             o_err
);
    localparam int WAIT_W = $clog2(WAIT_CYC + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(WAIT_CYC - 1);
    localparam logic [RES_W-1:0]  TIMEOUT_VAL = RES_W'(TIMEOUT_MS);
    localparam logic [31:0]       LOWER_VAL   = 32'(LOWER_MS);
    localparam logic [31:0]       UPPER_VAL   = 32'(UPPER_MS);

    rt_state_t         state;
    logic [RES_W-1:0]  target;
    logic [RES_W-1:0]  ms_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              tick;
    logic              tick_clear;

    // The tick phase is held at zero outside the timed states, so it restarts
    // on DELAY entry; DELAY->STIM happens on a tick, where it wraps to zero.
    assign tick_clear = (state != DELAY) && (state != STIM);

    ms_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .clear  (tick_clear),
        .o_tick (tick)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_lower <= LOWER_VAL;
            o_upper <= UPPER_VAL;
        end else begin
            o_lower <= LOWER_VAL;
            o_upper <= UPPER_VAL;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            o_gen      <= 1'b0;
            o_seed     <= '0;
            o_stim_led <= 1'b0;
            o_time_ms  <= '0;
            o_busy     <= 1'b0;
            o_early    <= 1'b0;
            o_timeout  <= 1'b0;
            o_err      <= 1'b0;
            target     <= '0;
            ms_cnt     <= '0;
            wait_cnt   <= '0;
        end else if (i_clear) begin
            state      <= IDLE;
            o_gen      <= 1'b0;
            o_stim_led <= 1'b0;
            o_time_ms  <= '0;
            o_busy     <= 1'b0;
            o_early    <= 1'b0;
            o_timeout  <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_gen <= 1'b0;
            case (state)
                IDLE, RESULT: begin
                    if (i_start) begin
                        state     <= REQ;
                        o_seed    <= i_seed;
                        o_busy    <= 1'b1;
                        o_early   <= 1'b0;
                        o_timeout <= 1'b0;
                    end
                end
                REQ: begin
                    if (i_rg_ready) begin
                        o_gen    <= 1'b1;
                        wait_cnt <= '0;
                        state    <= WAIT_RAND;
                    end
                end
                WAIT_RAND: begin
                    if (i_rg_invalid) begin
                        state  <= ERR;
                        o_err  <= 1'b1;
                        o_busy <= 1'b0;
                    end else if (i_rg_done) begin
                        if (i_rg_val >= LOWER_VAL && i_rg_val <= UPPER_VAL) begin
                            target <= i_rg_val[RES_W-1:0];
                            ms_cnt <= '0;
                            state  <= DELAY;
                        end else begin
                            state  <= ERR;
                            o_err  <= 1'b1;
                            o_busy <= 1'b0;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        state  <= ERR;
                        o_err  <= 1'b1;
                        o_busy <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DELAY: begin
                    if (i_stop) begin
                        state     <= RESULT;
                        o_early   <= 1'b1;
                        o_time_ms <= EARLY_CODE;
                        o_busy    <= 1'b0;
                    end else if (tick) begin
                        if (sat_inc(ms_cnt) >= target) begin
                            state      <= STIM;
                            o_stim_led <= 1'b1;
                            ms_cnt     <= '0;
                        end else begin
                            ms_cnt <= sat_inc(ms_cnt);
                        end
                    end
                end
                STIM: begin
                    // A stop reports the count before any same-cycle tick.
                    if (i_stop) begin
                        state      <= RESULT;
                        o_time_ms  <= ms_cnt;
                        o_stim_led <= 1'b0;
                        o_busy     <= 1'b0;
                    end else if (tick) begin
                        if (sat_inc(ms_cnt) >= TIMEOUT_VAL) begin
                            state      <= RESULT;
                            o_timeout  <= 1'b1;
                            o_time_ms  <= TIMEOUT_VAL;
                            o_stim_led <= 1'b0;
                            o_busy     <= 1'b0;
                        end else begin
                            ms_cnt <= sat_inc(ms_cnt);
                        end
                    end
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reaction_timer_ctrl.sv
`default_nettype none
// ============================================================================
// tb_reaction_timer_ctrl : directed bench with a hand-driven rand_gen model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_reaction_timer_ctrl;
    localparam int CLK_FREQ   = 10_000;
    localparam int LOWER_MS   = 20;
    localparam int UPPER_MS   = 150;
    localparam int TIMEOUT_MS = 100;
    localparam int WAIT_CYC   = 1000;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, clear;
    logic [31:0] seed;
    logic        gen;
    logic [31:0] o_seed, o_lower, o_upper;
    logic        rg_ready, rg_done, rg_invalid;
    logic [31:0] rg_val;
    logic        led;
    logic [13:0] time_ms;
    logic        busy, early, timeout, err;

    int   checks = 0;
    int   errors = 0;
    int   n;
    logic seen;
    logic lit;

    always #5 clk = ~clk;

    reaction_timer_ctrl #(
        .CLK_FREQ(CLK_FREQ), .LOWER_MS(LOWER_MS), .UPPER_MS(UPPER_MS),
        .TIMEOUT_MS(TIMEOUT_MS), .WAIT_CYC(WAIT_CYC)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
        .i_clear(clear), .i_seed(seed), .o_gen(gen), .o_seed(o_seed),
        .o_lower(o_lower), .o_upper(o_upper), .i_rg_ready(rg_ready),
        .i_rg_done(rg_done), .i_rg_invalid(rg_invalid), .i_rg_val(rg_val),
        .o_stim_led(led), .o_time_ms(time_ms), .o_busy(busy),
        .o_early(early), .o_timeout(timeout), .o_err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
    endtask

    task automatic wait_gen(input string tag);
        n = 0; seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk); n++;
            if (gen) seen = 1'b1;
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    // Present a done/value pair for one cycle; returns one negedge after the sampling edge.
    task automatic give_rand(input logic [31:0] v);
        rg_val = v; rg_done = 1'b1;
        @(negedge clk); rg_done = 1'b0;
    endtask

    task automatic wait_led(input int limit);
        n = 1;
        while (!led && n < limit) begin @(negedge clk); n++; end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; seed = '0;
        rg_ready = 1'b1; rg_done = 1'b0; rg_invalid = 1'b0; rg_val = '0;
        repeat (3) @(negedge clk);
        chk("rst_gen", {31'd0, gen}, 0);
        chk("rst_led", {31'd0, led}, 0);
        chk("rst_time", {18'd0, time_ms}, 0);
        chk("rst_flags", {28'd0, busy, early, timeout, err}, 0);
        chk("rst_seed", o_seed, 0);
        chk("rst_lower", o_lower, 20);
        chk("rst_upper", o_upper, 150);
        @(negedge clk); rst_n = 1'b1;

        // Normal run: delay 37 ms, stop 254 cycles into STIM.
        seed = 32'hDEADBEEF;
        pulse_start();
        seed = 32'h0;
        wait_gen("norm_gen_seen");
        chk("norm_gen_latency", n, 1);
        chk("norm_seed", o_seed, 32'hDEADBEEF);
        give_rand(37);
        chk("norm_gen_single", {31'd0, gen}, 0);
        chk("norm_busy", {31'd0, busy}, 1);
        wait_led(600);
        chk("norm_led_delay", {31'd0, (n - 1 >= 368) && (n - 1 <= 372)}, 1);
        repeat (253) @(negedge clk);
        stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        chk("norm_time", {18'd0, time_ms}, 25);
        chk("norm_flags", {28'd0, busy, early, timeout, err}, 0);
        chk("norm_led_off", {31'd0, led}, 0);

        // Early press 100 cycles into DELAY.
        pulse_start();
        wait_gen("early_gen_seen");
        give_rand(50);
        lit = led;
        for (int k = 0; k < 99; k++) begin
            @(negedge clk); lit = lit | led;
        end
        stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        chk("early_flag", {31'd0, early}, 1);
        chk("early_time", {18'd0, time_ms}, 9999);
        chk("early_led_never", {31'd0, lit | led}, 0);
        chk("early_busy", {31'd0, busy}, 0);

        // Restart from RESULT, then timeout with no stop.
        pulse_start();
        chk("restart_early_clr", {31'd0, early}, 0);
        chk("restart_busy", {31'd0, busy}, 1);
        wait_gen("to_gen_seen");
        give_rand(20);
        wait_led(400);
        chk("to_led_on", {31'd0, led}, 1);
        n = 0;
        while (!timeout && n < 1100) begin @(negedge clk); n++; end
        chk("to_latency", n, 1000);
        chk("to_time", {18'd0, time_ms}, 100);
        chk("to_led_off", {31'd0, led}, 0);

        // Ready gating, then invalid one cycle after o_gen.
        rg_ready = 1'b0;
        pulse_start();
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk); seen = seen | gen;
        end
        chk("gate_no_gen", {31'd0, seen}, 0);
        chk("gate_busy", {31'd0, busy}, 1);
        rg_ready = 1'b1;
        wait_gen("gate_gen_seen");
        chk("gate_gen_latency", n, 1);
        rg_invalid = 1'b1;
        @(negedge clk); rg_invalid = 1'b0;
        chk("inv_gen_single", {31'd0, gen}, 0);
        chk("inv_err", {31'd0, err}, 1);
        chk("inv_busy", {31'd0, busy}, 0);
        pulse_clear();
        chk("clr_flags", {28'd0, busy, early, timeout, err}, 0);
        chk("clr_time", {18'd0, time_ms}, 0);

        // Out-of-range value.
        pulse_start();
        wait_gen("oor_gen_seen");
        give_rand(5);
        chk("oor_err", {31'd0, err}, 1);
        pulse_clear();
        chk("oor_clr", {31'd0, err}, 0);

        // No done at all: ERR exactly WAIT_CYC cycles after o_gen.
        pulse_start();
        wait_gen("nodone_gen_seen");
        repeat (999) @(negedge clk);
        chk("nodone_err_pre", {31'd0, err}, 0);
        chk("nodone_busy_pre", {31'd0, busy}, 1);
        @(negedge clk);
        chk("nodone_err", {31'd0, err}, 1);
        pulse_clear();

        // Asynchronous reset mid-STIM.
        seed = 32'h12345678;
        pulse_start();
        wait_gen("rst_gen_seen");
        chk("rst_run_seed", o_seed, 32'h12345678);
        give_rand(20);
        wait_led(400);
        chk("rst_run_led", {31'd0, led}, 1);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_led", {31'd0, led}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_seed", o_seed, 0);
        chk("arst_lower", o_lower, 20);
        chk("arst_upper", o_upper, 150);
        @(negedge clk); rst_n = 1'b1;

        // Clear mid-DELAY: back to IDLE, LED never lights afterwards.
        pulse_start();
        wait_gen("cdly_gen_seen");
        give_rand(30);
        repeat (50) @(negedge clk);
        chk("cdly_busy_pre", {31'd0, busy}, 1);
        clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        chk("cdly_busy", {31'd0, busy}, 0);
        lit = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk); lit = lit | led | busy;
        end
        chk("cdly_idle", {31'd0, lit}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
